// File: rtl/num_fetch_pkg.sv
// Shared types, geometry constants and address helper for the numeric glyph row fetcher.
// Glyphs are stored digit-major, then row, then column byte.
package num_fetch_pkg;

  localparam int DIGITS      = 10;
  localparam int GLYPH_ROWS  = 16;
  localparam int ROW_BYTES   = 8;
  localparam int GLYPH_BYTES = GLYPH_ROWS * ROW_BYTES;
  localparam int ROM_DEPTH   = DIGITS * GLYPH_BYTES;
  localparam int ADDR_W      = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAST
  } fetch_state_e;

  function automatic logic [31:0] glyph_addr(input logic [3:0] digit,
                                             input logic [3:0] row,
                                             input logic [7:0] col);
    return 32'(digit) * 32'(GLYPH_BYTES) + 32'(row) * 32'(ROW_BYTES) + 32'(col);
  endfunction

endpackage

// File: rtl/num_fetch_rr_arb.sv
// Two-way round-robin grant for the score-display row requests.
// The last winner is remembered only when a request is actually accepted.
module num_fetch_rr_arb (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_accept,
  output logic o_grant0,
  output logic o_grant1
);

  logic r_lastGrant1;

  // Starts as "1 won last" so requester 0 takes the very first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lastGrant1 <= 1'b1;
    end else if (i_accept) begin
      r_lastGrant1 <= o_grant1;
    end
  end

  assign o_grant0 = i_req0 && (!i_req1 || r_lastGrant1);
  assign o_grant1 = i_req1 && (!i_req0 || !r_lastGrant1);

endmodule

// File: rtl/num_glyph_fetch.sv
// Fetches one 64-bit glyph row (8 palette bytes) from a synchronous ROM for one of two displays.
// Optional macro NUM_FETCH_RANGE_CHK_EN: out-of-range digits skip the ROM and answer line=0 with rsp_err.
module num_glyph_fetch #(
  parameter int DIGITS     = num_fetch_pkg::DIGITS,
  parameter int GLYPH_ROWS = num_fetch_pkg::GLYPH_ROWS,
  parameter int ROW_BYTES  = num_fetch_pkg::ROW_BYTES,
  parameter int ADDR_W     = num_fetch_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [3:0]             req0_digit,
  input  logic [3:0]             req0_row,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [3:0]             req1_digit,
  input  logic [3:0]             req1_row,
  output logic                   rsp0_valid,
  output logic [8*ROW_BYTES-1:0] rsp0_line,
  output logic                   rsp1_valid,
  output logic [8*ROW_BYTES-1:0] rsp1_line,
  output logic                   rsp_err,
  output logic [ADDR_W-1:0]      rom_address,
  output logic                   rom_chipselect,
  output logic                   rom_clken,
  input  logic [7:0]             rom_readdata,
  output logic                   busy
);
  import num_fetch_pkg::*;

  localparam int LINE_W   = 8 * ROW_BYTES;
  localparam int COL_W    = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
  localparam int DIGIT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int ROW_W    = (GLYPH_ROWS > 1) ? $clog2(GLYPH_ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_BYTES - 1);

  fetch_state_e        r_state;
  logic [COL_W-1:0]    r_col;
  logic [DIGIT_W-1:0]  r_digit;
  logic [ROW_W-1:0]    r_row;
  logic                r_id;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cs;
  logic                r_clken;
  logic                r_cap;
  logic [COL_W-1:0]    r_capCol;
  logic [LINE_W-9:0]   r_line;
  logic                r_rsp0Valid;
  logic                r_rsp1Valid;
  logic                r_rspErr;
  logic [LINE_W-1:0]   r_rsp0Line;
  logic [LINE_W-1:0]   r_rsp1Line;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_idle;
  logic                w_accept;
  logic [3:0]          w_selDigit;
  logic [3:0]          w_selRow;
  logic                w_digitBad;
  logic [ADDR_W-1:0]   w_addrFirst;
  logic [ADDR_W-1:0]   w_addrNext;
  logic [LINE_W-1:0]   w_fullLine;

  num_fetch_rr_arb u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req0   (req0_valid),
    .i_req1   (req1_valid),
    .i_accept (w_accept),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle && (w_grant0 || w_grant1);
  assign w_selDigit = w_grant1 ? req1_digit : req0_digit;
  assign w_selRow   = w_grant1 ? req1_row   : req0_row;

`ifdef NUM_FETCH_RANGE_CHK_EN
  assign w_digitBad = (32'(w_selDigit) >= 32'(DIGITS));
`else
  assign w_digitBad = 1'b0;
`endif

  assign w_addrFirst = ADDR_W'(glyph_addr(w_selDigit, w_selRow, 8'd0));
  assign w_addrNext  = ADDR_W'(glyph_addr(4'(r_digit), 4'(r_row), 8'(r_col) + 8'd1));

  // The last byte arrives during LAST, so it is spliced in directly at the response edge.
  assign w_fullLine  = {rom_readdata, r_line};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_digit     <= '0;
      r_row       <= '0;
      r_id        <= 1'b0;
      r_err       <= 1'b0;
      r_addr      <= '0;
      r_cs        <= 1'b0;
      r_clken     <= 1'b0;
      r_cap       <= 1'b0;
      r_capCol    <= '0;
      r_line      <= '0;
      r_rsp0Valid <= 1'b0;
      r_rsp1Valid <= 1'b0;
      r_rspErr    <= 1'b0;
      r_rsp0Line  <= '0;
      r_rsp1Line  <= '0;
    end else begin
      r_clken     <= 1'b1;
      r_rsp0Valid <= 1'b0;
      r_rsp1Valid <= 1'b0;
      r_rspErr    <= 1'b0;
      r_cap       <= (r_state == ST_FETCH);
      r_capCol    <= r_col;
      for (int b = 0; b < ROW_BYTES - 1; b++) begin
        if (r_cap && (r_capCol == COL_W'(b))) begin
          r_line[8*b +: 8] <= rom_readdata;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_FETCH;
            r_col   <= '0;
            r_digit <= DIGIT_W'(w_selDigit);
            r_row   <= ROW_W'(w_selRow);
            r_id    <= w_grant1;
            r_err   <= w_digitBad;
            r_addr  <= w_addrFirst;
            r_cs    <= !w_digitBad;
          end
        end
        ST_FETCH: begin
          if (r_col == COL_LAST) begin
            r_state <= ST_LAST;
            r_cs    <= 1'b0;
          end else begin
            r_col  <= r_col + 1'b1;
            r_addr <= w_addrNext;
          end
        end
        ST_LAST: begin
          r_state  <= ST_IDLE;
          r_col    <= '0;
          r_rspErr <= r_err;
          if (r_id) begin
            r_rsp1Valid <= 1'b1;
            r_rsp1Line  <= r_err ? '0 : w_fullLine;
          end else begin
            r_rsp0Valid <= 1'b1;
            r_rsp0Line  <= r_err ? '0 : w_fullLine;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready     = w_idle && w_grant0;
  assign req1_ready     = w_idle && w_grant1;
  assign rsp0_valid     = r_rsp0Valid;
  assign rsp1_valid     = r_rsp1Valid;
  assign rsp0_line      = r_rsp0Line;
  assign rsp1_line      = r_rsp1Line;
  assign rsp_err        = r_rspErr;
  assign rom_address    = r_addr;
  assign rom_chipselect = r_cs;
  assign rom_clken      = r_clken;
  assign busy           = !w_idle;

endmodule
